rf_write_scheduler: RTL and testbench
=====================================

Name: rf_write_scheduler

Overview:
- Shares the register file's single write port between two requesters: the pipeline WB stage and the multi-cycle multiply/divide unit (MDU).
- Keeps a per-register scoreboard of MDU results that are still pending, and stalls ID on RAW or WAW hazards against those registers.
- Sits between the WB stage, the MDU and the register file, and drives the RF write controls (RegWrite, RdAddr, RdData).

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NUM_REGS, 32, scoreboard entries (must equal 2**ADDR_W)
- BUF_DEPTH, 2, MDU result buffer depth (power of two, at least 2)
- STARVE_MAX, 4, consecutive cycles the buffer head may be blocked before it preempts WB

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous active-high reset
- wb_valid  in  1  WB stage has a register write this cycle
- wb_addr  in  ADDR_W  WB destination register
- wb_data  in  DATA_W  WB write data
- wb_stall  out  1  WB denied the port this cycle; pipeline holds MEM/WB
- mdu_issue  in  1  MDU op issued from ID this cycle
- mdu_issue_addr  in  ADDR_W  MDU op destination register
- issue_ready  out  1  issue accepted (the destination is not pending)
- mdu_valid  in  1  MDU result available
- mdu_addr  in  ADDR_W  result destination register
- mdu_data  in  DATA_W  result data
- mdu_ready  out  1  buffer can accept a result
- id_rs_addr, id_rt_addr, id_rd_addr  in  ADDR_W each  ID-stage source and destination registers
- stall_id  out  1  ID hazard against a pending register
- RegWrite  out  1  RF write enable
- RdAddr  out  ADDR_W  RF write address
- RdData  out  DATA_W  RF write data

Behaviour:
- Reset (asynchronous, active-high): pending vector cleared to 0; buffer emptied (pointers and count = 0); starve_cnt = 0.
  - After reset: RegWrite=0, RdAddr=0, RdData=0, wb_stall=0, stall_id=0, mdu_ready=1, issue_ready=1.
  - A reset in mid-operation drops all buffered results and pending marks; nothing is written afterwards.
- Scoreboard:
  - issue_ready = !pending[mdu_issue_addr].
  - On posedge with mdu_issue && issue_ready && mdu_issue_addr!=0: set pending[mdu_issue_addr].
  - Issue to register 0 is accepted and never marked pending.
- Buffer: FIFO of {addr, data}.
  - mdu_ready = (count < BUF_DEPTH); it is based on registered count only, so there is no pass-through when full.
  - Push on posedge when mdu_valid && mdu_ready.
- Write-port grant (combinational, same cycle):
  - wb_req = wb_valid && wb_addr!=0. A WB write to register 0 is discarded and never takes the port.
  - buf_req = count != 0.
  - preempt = buf_req && starve_cnt == STARVE_MAX.
  - If preempt: grant buffer head; wb_stall = wb_req.
  - Else if wb_req: grant WB; wb_stall = 0.
  - Else if buf_req: grant buffer head.
  - Else: RegWrite=0, RdAddr=0, RdData=0.
  - When the buffer is granted: pop the head on posedge and clear pending[head.addr] on the same posedge.
- Starvation counter:
  - Increments when buf_req && wb_req && !preempt.
  - Resets to 0 on any buffer grant or when the buffer is empty.
  - Saturates at STARVE_MAX.
- Hazard detect:
  - busy(a) = a!=0 && pending[a] && !(buffer granted && head.addr==a).
  - The clear-override applies because the RF writes on negedge, so ID reads the new value in the same cycle.
  - stall_id = busy(id_rs_addr) | busy(id_rt_addr) | busy(id_rd_addr). The rd term blocks WAW.
- Simultaneous events:
  - Push and pop in the same cycle: count is unchanged.
  - Issue to an address whose pending bit is being cleared in the same cycle: rejected (issue_ready is based on the registered bit); it succeeds the next cycle.
  - A result for a non-pending address is still buffered and written (protocol violation; the bench flags it with an assertion).
- Latency: an MDU result reaches the RF no earlier than the cycle after it is pushed.

Decomposition:
- Shared package holds:
  - the REG_MEM_SIZE-consistent NUM_REGS constant
  - ADDR_W and DATA_W
  - the buffer entry typedef {addr, data}
  - the grant-source enum {GNT_NONE, GNT_WB, GNT_BUF}
- One sub-module: rf_wb_fifo, a generic BUF_DEPTH synchronous FIFO with async reset. Scoreboard, arbiter and starvation logic stay in the top.

Test Plan:
- Reset check: hold rst high mid-buffer (count=2, pending[5], pending[9]). Required: count=0, pending=0, RegWrite=0, mdu_ready=1 immediately, without waiting for a clock edge.
- Idle-port drain: issue to r8, then push a result for r8 with data 0xDEADBEEF while wb_valid=0. Required: next cycle RegWrite=1, RdAddr=8, RdData=0xDEADBEEF; pending[8] cleared at that posedge; stall_id on rs=8 is 1 before that cycle and 0 during it.
- Starvation preemption: buffer holds r3, and wb_valid=1 to r4 every cycle. Required: WB is granted for 4 cycles, then on the 5th cycle the buffer is granted with wb_stall=1; WB is granted on the following cycle.
- Register 0 handling: wb_valid=1 with wb_addr=0 while the buffer holds r7. Required: the buffer is granted in the same cycle and wb_stall=0. Issue to r0: issue_ready=1 and no pending bit is set.
- Buffer full: three back-to-back MDU results while WB occupies the port. Required: the third result sees mdu_ready=0 and is not pushed; it is accepted once a pop occurs.
- WAW and issue hazards: with pending[12] set, ID presents rd=12 -> stall_id=1. A second issue to r12 -> issue_ready=0. An issue to r12 in the cycle its result is written -> still rejected; it is accepted on the following cycle.

Source files
------------

// File: rtl/rf_write_scheduler_pkg.sv
// Shared types and sizes for the register-file write scheduler.
// Each MDU result is buffered as an {addr, data} entry.
package rf_write_scheduler_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } buf_entry_t;

    typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_BUF} gnt_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Generic synchronous FIFO with asynchronous active-high reset.
// The caller never pushes when full and never pops when empty.
module rf_wb_fifo #(
    parameter int unsigned Width = 37,
    parameter int unsigned Depth = 2,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the RF write port between WB and buffered MDU results, and keeps
// the pending-register scoreboard used to stall ID on RAW/WAW hazards.
module rf_write_scheduler #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              mdu_issue,
    input  logic [ADDR_W-1:0] mdu_issue_addr,
    output logic              issue_ready,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic [ADDR_W-1:0] id_rd_addr,
    output logic              stall_id,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] RdAddr,
    output logic [DATA_W-1:0] RdData
);
    import rf_write_scheduler_pkg::*;

    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [StW-1:0]      starve_q, starve_d;
    logic [CntW-1:0]     count;
    buf_entry_t          head, push_entry;
    gnt_src_e            gnt;
    logic                wb_req, buf_req, preempt, push, pop;

    function automatic logic is_busy(input logic [ADDR_W-1:0]   a,
                                     input logic [NUM_REGS-1:0] pend,
                                     input logic                clr,
                                     input logic [ADDR_W-1:0]   clr_addr);
        return (a != '0) && pend[a] && !(clr && (clr_addr == a));
    endfunction

    assign wb_req     = wb_valid && (wb_addr != '0);
    assign buf_req    = (count != '0);
    assign preempt    = buf_req && (starve_q == StW'(STARVE_MAX));
    assign mdu_ready  = (count < CntW'(BUF_DEPTH));
    assign push       = mdu_valid && mdu_ready;
    assign pop        = (gnt == GNT_BUF);
    assign push_entry = '{addr: mdu_addr, data: mdu_data};

    rf_wb_fifo #(
        .Width ($bits(buf_entry_t)),
        .Depth (BUF_DEPTH),
        .CntW  (CntW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

    always_comb begin
        gnt      = GNT_NONE;
        wb_stall = 1'b0;
        if (preempt) begin
            gnt      = GNT_BUF;
            wb_stall = wb_req;
        end else if (wb_req) begin
            gnt = GNT_WB;
        end else if (buf_req) begin
            gnt = GNT_BUF;
        end
    end

    always_comb begin
        RegWrite = 1'b0;
        RdAddr   = '0;
        RdData   = '0;
        unique case (gnt)
            GNT_WB: begin
                RegWrite = 1'b1;
                RdAddr   = wb_addr;
                RdData   = wb_data;
            end
            GNT_BUF: begin
                RegWrite = 1'b1;
                RdAddr   = head.addr;
                RdData   = head.data;
            end
            default: ;
        endcase
    end

    assign issue_ready = !pending_q[mdu_issue_addr];

    // RF writes on negedge, so a register being cleared this cycle is already readable.
    assign stall_id = is_busy(id_rs_addr, pending_q, pop, head.addr)
                    | is_busy(id_rt_addr, pending_q, pop, head.addr)
                    | is_busy(id_rd_addr, pending_q, pop, head.addr);

    always_comb begin
        pending_d = pending_q;
        if (pop) pending_d[head.addr] = 1'b0;
        if (mdu_issue && issue_ready && (mdu_issue_addr != '0)) begin
            pending_d[mdu_issue_addr] = 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!buf_req || pop) begin
            starve_d = '0;
        end else if (wb_req && !preempt) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            starve_q  <= '0;
        end else begin
            pending_q <= pending_d;
            starve_q  <= starve_d;
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: vector table, directed corner sequences, and
// randomized traffic checked against a queue-based model of the write scheduler.
module tb_rf_write_scheduler;

    localparam int STARVE_MAX = 4;
    localparam int BUF_DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, mdu_issue, mdu_valid;
    logic [4:0]  wb_addr, mdu_issue_addr, mdu_addr, id_rs_addr, id_rt_addr, id_rd_addr;
    logic [31:0] wb_data, mdu_data;
    logic        wb_stall, issue_ready, mdu_ready, stall_id, RegWrite;
    logic [4:0]  RdAddr;
    logic [31:0] RdData;

    always #5 clk = ~clk;

    rf_write_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .wb_stall       (wb_stall),
        .mdu_issue      (mdu_issue),
        .mdu_issue_addr (mdu_issue_addr),
        .issue_ready    (issue_ready),
        .mdu_valid      (mdu_valid),
        .mdu_addr       (mdu_addr),
        .mdu_data       (mdu_data),
        .mdu_ready      (mdu_ready),
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .id_rd_addr     (id_rd_addr),
        .stall_id       (stall_id),
        .RegWrite       (RegWrite),
        .RdAddr         (RdAddr),
        .RdData         (RdData)
    );

    int vecs = 0;
    int errs = 0;

    // Reference model: result queue, pending set, starvation count.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    ent_t       m_q[$];
    bit         m_pend [32];
    int         m_starve;
    logic [4:0] outstanding[$];
    bit          m_gbuf, m_gwb, m_wbr, m_bq, m_pre, m_push;
    logic        e_we, e_wbs, e_sid, e_mrdy, e_irdy;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    typedef struct {
        logic        wv;  logic [4:0] wa; logic [31:0] wd;
        logic        iv;  logic [4:0] ia;
        logic        mv;  logic [4:0] ma; logic [31:0] md;
        logic [4:0]  rs;  logic [4:0] rt; logic [4:0]  rd;
        logic        we;  logic [4:0] addr; logic [31:0] data;
        logic        wbs; logic sid; logic mrdy; logic irdy;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        outstanding.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_starve = 0;
    endtask

    function automatic bit model_busy(input logic [4:0] a);
        return (a != 5'd0) && m_pend[a] && !(m_gbuf && m_q[0].a == a);
    endfunction

    task automatic model_eval();
        m_wbr  = wb_valid && (wb_addr != 5'd0);
        m_bq   = (m_q.size() != 0);
        m_pre  = m_bq && (m_starve == STARVE_MAX);
        m_gbuf = m_pre || (m_bq && !m_wbr);
        m_gwb  = m_wbr && !m_pre;
        e_we   = m_gbuf || m_gwb;
        e_addr = 5'd0;
        e_data = 32'd0;
        if (m_gbuf) begin
            e_addr = m_q[0].a;
            e_data = m_q[0].d;
        end else if (m_gwb) begin
            e_addr = wb_addr;
            e_data = wb_data;
        end
        e_wbs  = m_pre && m_wbr;
        e_mrdy = (m_q.size() < BUF_DEPTH);
        e_irdy = !m_pend[mdu_issue_addr];
        e_sid  = model_busy(id_rs_addr) || model_busy(id_rt_addr) || model_busy(id_rd_addr);
        m_push = mdu_valid && e_mrdy;
        if (mdu_valid)
            assert (m_pend[mdu_addr])
            else $error("protocol violation: MDU result for non-pending r%0d", mdu_addr);
    endtask

    task automatic model_commit();
        if (m_gbuf) begin
            m_pend[m_q[0].a] = 1'b0;
            m_q.delete(0);
        end
        if (m_push) begin
            m_q.push_back('{a: mdu_addr, d: mdu_data});
            foreach (outstanding[i]) begin
                if (outstanding[i] == mdu_addr) begin
                    outstanding.delete(i);
                    break;
                end
            end
        end
        if (mdu_issue && e_irdy && mdu_issue_addr != 5'd0) begin
            m_pend[mdu_issue_addr] = 1'b1;
            outstanding.push_back(mdu_issue_addr);
        end
        if (!m_bq || m_gbuf) m_starve = 0;
        else if (m_wbr && !m_pre && m_starve < STARVE_MAX) m_starve++;
    endtask

    task automatic check_model();
        check("RegWrite",    64'(RegWrite),    64'(e_we));
        check("RdAddr",      64'(RdAddr),      64'(e_addr));
        check("RdData",      64'(RdData),      64'(e_data));
        check("wb_stall",    64'(wb_stall),    64'(e_wbs));
        check("stall_id",    64'(stall_id),    64'(e_sid));
        check("mdu_ready",   64'(mdu_ready),   64'(e_mrdy));
        check("issue_ready", 64'(issue_ready), 64'(e_irdy));
    endtask

    task automatic settle(input bit use_model);
        #1;
        model_eval();
        if (use_model) check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic set_idle();
        wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        mdu_issue = 1'b0; mdu_issue_addr = 5'd0;
        mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_rd_addr = 5'd0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            settle(1'b1);
            advance();
        end
    endtask

    task automatic issue_cycle(input logic [4:0] a);
        set_idle();
        mdu_issue = 1'b1; mdu_issue_addr = a;
        settle(1'b1);
        advance();
    endtask

    initial begin
        // wv wa wd | iv ia | mv ma md | rs rt rd || we addr data wbs sid mrdy irdy
        tbl[0] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd8, 1'b0, 5'd0, 32'h0,        5'd8, 5'd0, 5'd0,
                   1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd8, 1'b0, 5'd0, 32'h0,        5'd8, 5'd0, 5'd0,
                   1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd0, 5'd0,
                   1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd8, 5'd0, 5'd0,
                   1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd8, 1'b0, 5'd0, 32'h0,        5'd8, 5'd0, 5'd0,
                   1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0,
                   1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 5'd0, 32'h1234, 1'b0, 5'd7, 1'b1, 5'd7, 32'h77,       5'd0, 5'd7, 5'd0,
                   1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 5'd0,
                   1'b1, 5'd7, 32'h77,       1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd7,
                   1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b1, 5'd5, 32'h55,   1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0,
                   1'b1, 5'd5, 32'h55,       1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table: idle drain of r8, r0 handling, plain WB write.
        for (int i = 0; i < 10; i++) begin
            wb_valid = tbl[i].wv; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
            mdu_issue = tbl[i].iv; mdu_issue_addr = tbl[i].ia;
            mdu_valid = tbl[i].mv; mdu_addr = tbl[i].ma; mdu_data = tbl[i].md;
            id_rs_addr = tbl[i].rs; id_rt_addr = tbl[i].rt; id_rd_addr = tbl[i].rd;
            settle(1'b0);
            check($sformatf("tbl%0d.RegWrite", i),    64'(RegWrite),    64'(tbl[i].we));
            check($sformatf("tbl%0d.RdAddr", i),      64'(RdAddr),      64'(tbl[i].addr));
            check($sformatf("tbl%0d.RdData", i),      64'(RdData),      64'(tbl[i].data));
            check($sformatf("tbl%0d.wb_stall", i),    64'(wb_stall),    64'(tbl[i].wbs));
            check($sformatf("tbl%0d.stall_id", i),    64'(stall_id),    64'(tbl[i].sid));
            check($sformatf("tbl%0d.mdu_ready", i),   64'(mdu_ready),   64'(tbl[i].mrdy));
            check($sformatf("tbl%0d.issue_ready", i), 64'(issue_ready), 64'(tbl[i].irdy));
            advance();
        end
        idle_cycles(2);

        // Starvation: r3 buffered while WB hammers r4.
        issue_cycle(5'd3);
        set_idle();
        mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h3333;
        settle(1'b1);
        advance();
        for (int i = 0; i < 6; i++) begin
            set_idle();
            wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h400 + 32'(i);
            settle(1'b1);
            check($sformatf("starve%0d.RdAddr", i),   64'(RdAddr),   (i == 4) ? 64'd3 : 64'd4);
            check($sformatf("starve%0d.wb_stall", i), 64'(wb_stall), (i == 4) ? 64'd1 : 64'd0);
            advance();
        end
        idle_cycles(2);

        // Buffer full: third result must wait for a pop.
        issue_cycle(5'd10);
        issue_cycle(5'd11);
        issue_cycle(5'd13);
        for (int i = 0; i < 3; i++) begin
            set_idle();
            wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'hA0 + 32'(i);
            mdu_valid = 1'b1; mdu_addr = (i == 0) ? 5'd10 : (i == 1) ? 5'd11 : 5'd13;
            mdu_data = 32'hB0 + 32'(i);
            settle(1'b1);
            check($sformatf("full%0d.mdu_ready", i), 64'(mdu_ready), (i == 2) ? 64'd0 : 64'd1);
            if (i < 2) advance();
        end
        begin
            bit accepted = 1'b0;
            bit popped = 1'b0;
            for (int k = 0; k < 10 && !accepted; k++) begin
                if (k > 0) settle(1'b1);
                if (mdu_ready) accepted = 1'b1;
                else if (RegWrite && RdAddr != 5'd4) popped = 1'b1;
                advance();
            end
            check("full.third_accepted", 64'(accepted), 64'd1);
            check("full.pop_before_accept", 64'(popped), 64'd1);
        end
        idle_cycles(4);

        // WAW and issue hazards on r12.
        issue_cycle(5'd12);
        set_idle();
        mdu_issue = 1'b1; mdu_issue_addr = 5'd12; id_rd_addr = 5'd12;
        settle(1'b1);
        check("waw.stall_id", 64'(stall_id), 64'd1);
        check("waw.issue_ready", 64'(issue_ready), 64'd0);
        advance();
        set_idle();
        mdu_valid = 1'b1; mdu_addr = 5'd12; mdu_data = 32'hC12;
        settle(1'b1);
        advance();
        set_idle();
        mdu_issue = 1'b1; mdu_issue_addr = 5'd12; id_rd_addr = 5'd12;
        settle(1'b1);
        check("waw.write_RdAddr", 64'(RdAddr), 64'd12);
        check("waw.issue_on_clear", 64'(issue_ready), 64'd0);
        check("waw.stall_on_clear", 64'(stall_id), 64'd0);
        advance();
        set_idle();
        mdu_issue = 1'b1; mdu_issue_addr = 5'd12;
        settle(1'b1);
        check("waw.issue_after", 64'(issue_ready), 64'd1);
        advance();
        idle_cycles(1);

        // Asynchronous reset with two results buffered.
        issue_cycle(5'd5);
        issue_cycle(5'd9);
        for (int i = 0; i < 2; i++) begin
            set_idle();
            wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
            mdu_valid = 1'b1; mdu_addr = (i == 0) ? 5'd5 : 5'd9; mdu_data = 32'h900 + 32'(i);
            settle(1'b1);
            advance();
        end
        set_idle();
        id_rs_addr = 5'd5; id_rt_addr = 5'd9; mdu_issue_addr = 5'd5;
        settle(1'b1);
        check("rst.pre_mdu_ready", 64'(mdu_ready), 64'd0);
        #1 rst = 1'b1;
        #1;
        check("rst.RegWrite", 64'(RegWrite), 64'd0);
        check("rst.RdAddr", 64'(RdAddr), 64'd0);
        check("rst.mdu_ready", 64'(mdu_ready), 64'd1);
        check("rst.stall_id", 64'(stall_id), 64'd0);
        check("rst.issue_ready", 64'(issue_ready), 64'd1);
        check("rst.wb_stall", 64'(wb_stall), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(3);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            wb_valid = ($urandom_range(0, 9) < 6);
            wb_addr = 5'($urandom_range(0, 31));
            wb_data = $urandom;
            mdu_issue = ($urandom_range(0, 3) == 0);
            mdu_issue_addr = 5'($urandom_range(0, 15));
            mdu_valid = (outstanding.size() != 0) && ($urandom_range(0, 2) == 0);
            mdu_addr = mdu_valid ? outstanding[0] : 5'd0;
            mdu_data = $urandom;
            id_rs_addr = 5'($urandom_range(0, 15));
            id_rt_addr = 5'($urandom_range(0, 15));
            id_rd_addr = 5'($urandom_range(0, 15));
            settle(1'b1);
            advance();
        end
        idle_cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
